aux_mem_cmp: RTL
================

Name: aux_mem_cmp

Overview:
- Parametrised successor of the fixed 8x256 auxiliary memory used by the PMBIST engine.
- Holds reference and scratch data for march sequences, with generic width and depth and a configurable read pipeline depth.
- Adds native read-compare: captured read data is checked against an expected word, and the block keeps fail status, a saturating fail count and the first failing address for the scan-out logic.
- Sits between the march sequencer (command source) and the result/scan collection logic.

Parameters:
- DW, 8, data word width (bits).
- AW, 8, address width; depth = 2**AW words.
- CSW, 3, command field width (MARCH_SEQ_FRMT_SIZE); only bits [2:0] are decoded.
- RD_LAT, 1, read latency in cycles from command accept to rd_valid; legal range 1..3.
- FCW, 8, fail counter width.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command strobe; cmd_in/addr_in/data_in/exp_in are sampled when high.
- cmd_in  in  CSW  bit0 = write, bit1 = read, bit2 = compare (meaningful only with bit1).
- addr_in  in  AW  word address.
- data_in  in  DW  write data.
- exp_in  in  DW  expected read data for compare.
- clr_status  in  1  clears fail, fail_count and first-fail capture.
- data_out  out  DW  read data, valid when rd_valid is high.
- rd_valid  out  1  one-cycle pulse per accepted read.
- cmp_fail  out  1  one-cycle pulse, aligned with rd_valid, on a compare mismatch.
- fail_sticky  out  1  set on any mismatch; held until rst or clr_status.
- fail_count  out  FCW  number of mismatches, saturating at all-ones.
- first_fail_addr  out  AW  address of the first mismatch since the last clear.
- first_fail_valid  out  1  first_fail_addr holds a captured address.

Behaviour:
- Reset (synchronous, active-high):
  - Outputs go to zero at the next edge: data_out, rd_valid, cmp_fail, fail_sticky, fail_count, first_fail_addr, first_fail_valid.
  - Read pipeline valid bits are cleared, so in-flight reads are dropped with no rd_valid.
  - RAM contents are not cleared.
- Command accept: on any edge with cmd_valid=1. With cmd_valid=0, cmd_in is ignored. No backpressure; one command per cycle.
- Write (bit0): mem[addr_in] <= data_in at the accept edge.
- Read (bit1):
  - Address, compare flag and exp_in enter a pipeline of RD_LAT stages.
  - The RAM output register is stage 1.
  - rd_valid and data_out appear exactly RD_LAT cycles after the accept edge. data_out holds its last value when rd_valid=0.
- Read and write in the same command (bit0 and bit1): read-before-write. data_out returns the old contents and the new data is stored. This implements r/w march elements in one cycle.
- Back-to-back: a read at address A accepted one cycle after a write to A returns the new data (no hazard, since the write has completed).
- Compare (bit1 and bit2): at the rd_valid cycle, mismatch = (data_out != exp_d), where exp_d is the delayed exp_in.
  - cmp_fail pulses with rd_valid.
  - fail_sticky is set on the following edge.
  - fail_count increments, saturating at 2**FCW-1 with no wrap.
  - If first_fail_valid=0, first_fail_addr captures the read address and first_fail_valid is set; later mismatches do not overwrite it.
- bit2 without bit1: ignored (treated as no read).
- cmd_in bits above [2]: ignored.
- clr_status:
  - Clears fail_sticky, fail_count and first_fail_* at the next edge.
  - If a mismatch resolves in the same cycle, clear wins and the mismatch is lost; cmp_fail still pulses.
  - Does not affect the pipeline.
- Address wrap: none needed; the full 2**AW range is valid.

Decomposition:
- Shared package (defines):
  - CMD_WR_BIT=0, CMD_RD_BIT=1, CMD_CMP_BIT=2.
  - RD_LAT_MIN=1, RD_LAT_MAX=3.
  - Defaults tied to DATA_WIDTH, ADDR_WIDTH and MARCH_SEQ_FRMT_SIZE.
- One sub-module, aux_mem_ram: a single-port inferred RAM, DW x 2**AW, read-before-write, registered output, synthesises to block RAM.
- Pipeline, compare and status logic live in the top level.

Test Plan:
- Reset then write 0xA5 to addr 0x10, read addr 0x10 (RD_LAT=1) → rd_valid high exactly 1 cycle after the read accept, data_out=0xA5, all status outputs 0.
- RD_LAT=3, back-to-back reads of addr 0..3 pre-written 0x00..0x03 → rd_valid high for 4 consecutive cycles starting 3 cycles after the first accept, data 0x00,0x01,0x02,0x03 in order.
- Addr 0x20 holds 0x55, then one command cmd=011 with data_in 0xAA → data_out=0x55; a following read returns 0xAA.
- Read-compare addr 0x30 (holds 0x0F) with exp 0x0F, then addr 0x31 (holds 0x00) with exp 0xFF → cmp_fail only on the second read, fail_count=1, first_fail_addr=0x31, fail_sticky=1.
- FCW=2, five mismatching compares → fail_count saturates at 3. Then clr_status → all status outputs return to 0 and the next mismatch recaptures first_fail_addr.
- Issue a read with RD_LAT=2, assert rst one cycle later → no rd_valid pulse, all outputs 0, and RAM contents are preserved on a subsequent read.

Source files
------------

// File: rtl/aux_mem_cmp_pkg.sv
// ---------------------------------------------------------------------------
// aux_mem_cmp_pkg
// Shared definitions for the PMBIST auxiliary memory with read-compare.
//   - Command bit positions decoded from the march sequencer command field.
//   - Legal read-latency range.
//   - Default widths carried over from the fixed 8x256 predecessor.
// ---------------------------------------------------------------------------
package aux_mem_cmp_pkg;

  // Default geometry of the original auxiliary memory.
  localparam int DATA_WIDTH          = 8;
  localparam int ADDR_WIDTH          = 8;
  localparam int MARCH_SEQ_FRMT_SIZE = 3;
  localparam int FAIL_CNT_WIDTH      = 8;

  // Command field bit positions. Compare is meaningful only together with read.
  localparam int CMD_WR_BIT  = 0;
  localparam int CMD_RD_BIT  = 1;
  localparam int CMD_CMP_BIT = 2;

  // Read latency from command accept to rd_valid. Stage 1 is the RAM output register.
  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 3;

endpackage : aux_mem_cmp_pkg

// File: rtl/aux_mem_ram.sv
// ---------------------------------------------------------------------------
// aux_mem_ram
// Single-port inferred RAM, DW x 2**AW, read-before-write, registered output.
// Maps onto a block RAM with a resettable output register.
//   clk    in   system clock
//   rst    in   synchronous active-high reset (output register only)
//   we     in   write enable: mem[addr] <= wdata
//   re     in   read enable: rdata <= mem[addr] (old contents on a same-cycle write)
//   addr   in   word address
//   wdata  in   write data
//   rdata  out  registered read data; holds when re is low
// ---------------------------------------------------------------------------
module aux_mem_ram
  import aux_mem_cmp_pkg::*;
#(
  parameter int DW = DATA_WIDTH,
  parameter int AW = ADDR_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  // NOTE: the storage array is deliberately left out of reset; a reset on the
  // array would prevent block-RAM mapping and march data must survive rst.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  // NOTE: non-blocking assignments give read-before-write for free: the read
  // below samples mem[addr] before the write above updates it.
  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[addr];
  end

endmodule : aux_mem_ram

// File: rtl/aux_mem_cmp.sv
// ---------------------------------------------------------------------------
// aux_mem_cmp
// Parametrised PMBIST auxiliary memory with native read-compare and fail
// status capture for the scan-out logic.
//   clk               in   system clock
//   rst               in   synchronous active-high reset
//   cmd_valid         in   command strobe; command fields sampled when high
//   cmd_in            in   bit0 write, bit1 read, bit2 compare (with read)
//   addr_in           in   word address
//   data_in           in   write data
//   exp_in            in   expected read data for compare
//   clr_status        in   clears fail_sticky, fail_count, first_fail_*
//   data_out          out  read data, valid with rd_valid; held otherwise
//   rd_valid          out  one-cycle pulse RD_LAT cycles after a read accept
//   cmp_fail          out  mismatch pulse aligned with rd_valid
//   fail_sticky       out  any mismatch since last clear
//   fail_count        out  saturating mismatch count
//   first_fail_addr   out  address of first mismatch since last clear
//   first_fail_valid  out  first_fail_addr holds a captured address
// RD_LAT outside RD_LAT_MIN..RD_LAT_MAX is clamped into that range.
// ---------------------------------------------------------------------------
module aux_mem_cmp
  import aux_mem_cmp_pkg::*;
#(
  parameter int DW     = DATA_WIDTH,
  parameter int AW     = ADDR_WIDTH,
  parameter int CSW    = MARCH_SEQ_FRMT_SIZE,
  parameter int RD_LAT = 1,
  parameter int FCW    = FAIL_CNT_WIDTH
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cmd_valid,
  input  logic [CSW-1:0] cmd_in,
  input  logic [AW-1:0]  addr_in,
  input  logic [DW-1:0]  data_in,
  input  logic [DW-1:0]  exp_in,
  input  logic           clr_status,
  output logic [DW-1:0]  data_out,
  output logic           rd_valid,
  output logic           cmp_fail,
  output logic           fail_sticky,
  output logic [FCW-1:0] fail_count,
  output logic [AW-1:0]  first_fail_addr,
  output logic           first_fail_valid
);

  localparam int LAT = (RD_LAT < RD_LAT_MIN) ? RD_LAT_MIN :
                       (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT;

  // Per-read bookkeeping travelling alongside the data.
  typedef struct packed {
    logic          vld;
    logic          cmp;
    logic [AW-1:0] addr;
    logic [DW-1:0] exp;
  } rd_meta_t;

  logic          do_wr;
  logic          do_rd;
  logic [DW-1:0] ram_rdata;
  rd_meta_t      meta_q [LAT];
  rd_meta_t      last;
  logic          mismatch;

  // Compare without read is not a read at all, so it never enters the pipeline.
  assign do_wr = cmd_valid & cmd_in[CMD_WR_BIT];
  assign do_rd = cmd_valid & cmd_in[CMD_RD_BIT];

  aux_mem_ram #(
    .DW (DW),
    .AW (AW)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (do_wr),
    .re    (do_rd),
    .addr  (addr_in),
    .wdata (data_in),
    .rdata (ram_rdata)
  );

  // meta_q[0] is aligned with the RAM output register (stage 1).
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) meta_q[i] <= '0;
    end else begin
      meta_q[0] <= '{vld:  do_rd,
                     cmp:  do_rd & cmd_in[CMD_CMP_BIT],
                     addr: addr_in,
                     exp:  exp_in};
      for (int i = 1; i < LAT; i++) meta_q[i] <= meta_q[i-1];
    end
  end

  // Data stages beyond the RAM register only load on a valid read, so
  // data_out holds its last value between reads.
  if (LAT == 1) begin : g_lat1
    assign data_out = ram_rdata;
  end else begin : g_latn
    logic [DW-1:0] data_q [LAT-1];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < LAT - 1; i++) data_q[i] <= '0;
      end else begin
        if (meta_q[0].vld) data_q[0] <= ram_rdata;
        for (int i = 1; i < LAT - 1; i++) begin
          if (meta_q[i].vld) data_q[i] <= data_q[i-1];
        end
      end
    end

    assign data_out = data_q[LAT-2];
  end

  assign last     = meta_q[LAT-1];
  assign rd_valid = last.vld;
  assign mismatch = last.vld & last.cmp & (data_out != last.exp);
  assign cmp_fail = mismatch;

  // clr_status shares the reset branch: a mismatch resolving in the same
  // cycle as a clear is intentionally dropped.
  always_ff @(posedge clk) begin
    if (rst || clr_status) begin
      fail_sticky      <= 1'b0;
      fail_count       <= '0;
      first_fail_addr  <= '0;
      first_fail_valid <= 1'b0;
    end else if (mismatch) begin
      fail_sticky <= 1'b1;
      if (fail_count != '1) fail_count <= fail_count + 1'b1;
      if (!first_fail_valid) begin
        first_fail_addr  <= last.addr;
        first_fail_valid <= 1'b1;
      end
    end
  end

endmodule : aux_mem_cmp
